input_debouncer: RTL
====================

Name: input_debouncer

Overview:
- Synchronises and debounces WIDTH asynchronous board inputs (slide switches, push buttons).
- Delivers glitch-free levels plus one-cycle edge pulses.
- Sits directly upstream of the three-input combinational logic stage: clean_out[0], [1], [2] drive its a, b and c inputs.
- Each channel is independent: a 2+-flop synchroniser feeds a per-channel stability counter that qualifies level changes.

Parameters:
- WIDTH, 3, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flops per channel; legal values are 2 or more.
- STABLE_CYCLES, 16, consecutive mismatching cycles required to accept a new level; legal values are 2 or more.
- CNT_W, $clog2(STABLE_CYCLES), counter width. This is a local parameter and is not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- raw_in  input  WIDTH  unsynchronised inputs; may change at any time.
- clean_out  output  WIDTH  debounced level, registered.
- rise_pulse  output  WIDTH  one-cycle pulse when clean_out[i] goes 0->1, registered.
- fall_pulse  output  WIDTH  one-cycle pulse when clean_out[i] goes 1->0, registered.
- any_change  output  1  OR of all rise_pulse and fall_pulse bits, combinational from registered bits.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, at any time, including mid-count):
  - All synchroniser flops, counters, clean_out, rise_pulse and fall_pulse go to 0 immediately, without waiting for a clock edge.
  - any_change = 0.
  - Deassertion is taken synchronously at the next rising edge; no partial count survives.
- Synchroniser:
  - s[i] is the last stage of a SYNC_STAGES-deep shift register clocked from raw_in[i].
  - No logic is placed between stages.
- Per-channel FSM, two states:
  - STABLE, when s[i]==clean_out[i]:
    - Counter held at 0.
    - Moves to PENDING on the first edge where s[i]!=clean_out[i]; the counter becomes 1 on that edge.
  - PENDING:
    - Each edge with s[i]!=clean_out[i] and counter<STABLE_CYCLES-1: counter increments.
    - Edge with s[i]!=clean_out[i] and counter==STABLE_CYCLES-1: clean_out[i]<=s[i]; counter<=0; the matching rise_pulse[i] or fall_pulse[i] <=1; return to STABLE.
    - Any edge with s[i]==clean_out[i]: counter<=0; return to STABLE; no output change. A bounce restarts qualification from zero.
- Acceptance rule: a raw level held for N consecutive sampled cycles is accepted if and only if N >= STABLE_CYCLES. Shorter pulses are fully rejected.
- Latency: a raw change first sampled at rising edge #1 appears on clean_out at edge #(SYNC_STAGES+STABLE_CYCLES). With defaults this is edge 18.
- Pulses:
  - rise_pulse[i] and fall_pulse[i] are high for exactly one cycle, aligned with the cycle in which clean_out[i] first shows its new value.
  - They are never both high for one channel.
  - Otherwise they are 0.
- Channels never interact. Simultaneous qualification on several channels updates all of them on the same edge, with the corresponding pulses high together and any_change=1 once.
- Counter never wraps: the maximum value reached is STABLE_CYCLES-1.
- No X propagation: every flop has a reset value.

Test Plan (defaults unless stated):
- Reset release, raw_in=3'b000 held for 30 cycles -> clean_out=000; rise_pulse, fall_pulse and any_change stay 0 throughout.
- raw_in[0] 0->1 sampled at edge 1 and held -> clean_out[0]=1 visible after edge 18 (not after edge 17); rise_pulse[0] and any_change high for exactly that one cycle; fall_pulse=000.
- Glitch rejection: raw_in[1] high for exactly 15 cycles, then low -> clean_out[1] stays 0 and no pulses. Repeat with 16 cycles -> clean_out[1] rises at edge 18, then falls 16 stable cycles after the input drops, with one fall_pulse[1].
- Bounce: raw_in[2] toggles every 5 cycles for 60 cycles, then holds 1 -> no change during toggling; clean_out[2]=1 exactly 18 edges after the final 0->1 sample.
- Simultaneous: raw_in 000->101 on the same edge -> clean_out=101 on edge 18; rise_pulse=101 for one cycle; any_change high one cycle.
- Mid-count reset: raw_in[0]=1 held, rst_n pulsed low at edge 10 for 3 cycles -> outputs 0 asynchronously during reset. After release, clean_out[0] rises 18 edges after the first post-reset sampling edge, not earlier.

Source files
------------

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Synchronises and debounces WIDTH asynchronous board inputs (slide switches,
// push buttons) and delivers glitch-free levels plus one-cycle edge pulses.
// Each channel is independent: a SYNC_STAGES-deep synchroniser feeds a
// two-state qualifier (STABLE / PENDING) with a stability counter. A new level
// is accepted only after STABLE_CYCLES consecutive sampled cycles that differ
// from the current clean level. Any bounce back restarts qualification.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   raw_in      in   WIDTH  unsynchronised inputs
//   clean_out   out  WIDTH  debounced level (registered)
//   rise_pulse  out  WIDTH  one-cycle pulse on clean_out 0->1 (registered)
//   fall_pulse  out  WIDTH  one-cycle pulse on clean_out 1->0 (registered)
//   any_change  out  1      OR of all rise/fall pulse bits
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int WIDTH         = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q  [WIDTH];
    logic [CNT_W-1:0]       cnt_q   [WIDTH];
    logic [CNT_W-1:0]       cnt_d   [WIDTH];
    state_t                 state_q [WIDTH];
    state_t                 state_d [WIDTH];
    logic [WIDTH-1:0]       clean_q;
    logic [WIDTH-1:0]       clean_d;
    logic [WIDTH-1:0]       rise_q;
    logic [WIDTH-1:0]       rise_d;
    logic [WIDTH-1:0]       fall_q;
    logic [WIDTH-1:0]       fall_d;
    logic [WIDTH-1:0]       sync_s;

    // Last synchroniser stage of every channel, the only value the qualifier sees.
    always_comb begin
        sync_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sync_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Plain shift-register synchroniser; nothing sits between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
            end
        end
    end

    // Per-channel qualifier next-state, counter and output logic.
    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (sync_s[i] != clean_q[i]) begin
                        state_d[i] = ST_PENDING;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                ST_PENDING: begin
                    if (sync_s[i] == clean_q[i]) begin
                        // Bounce back: discard the partial count.
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                        clean_d[i] = sync_s[i];
                        rise_d[i]  = sync_s[i];
                        fall_d[i]  = ~sync_s[i];
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Qualifier state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = |(rise_q | fall_q);

endmodule
